// File: rtl/multicycle_cpu.sv
// ============================================================================
// Module   : multicycle_cpu
// Brief    : FSM-sequenced MIPS-subset core with one shared req/ready memory port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic [2:0]        state,
  output logic              halted
);

  localparam logic [5:0] c_OP_R    = 6'h00;
  localparam logic [5:0] c_OP_J    = 6'h02;
  localparam logic [5:0] c_OP_BEQ  = 6'h04;
  localparam logic [5:0] c_OP_BNE  = 6'h05;
  localparam logic [5:0] c_OP_ADDI = 6'h08;
  localparam logic [5:0] c_OP_LW   = 6'h23;
  localparam logic [5:0] c_OP_SW   = 6'h2B;

  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_npc, r_a, r_b, r_aluout, r_mdr;
  logic [31:0] r_regs [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest;
  logic [31:0] w_sext, w_alu, w_wb_data, w_br_target, w_j_target;
  logic        w_funct_ok, w_op_ok, w_unused;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_funct  = r_ir[5:0];
  assign w_unused = ^r_ir[10:6];
  assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};

  assign w_br_target = r_npc + {w_sext[29:0], 2'b00};
  assign w_j_target  = {r_npc[31:28], r_ir[25:0], 2'b00};
  assign w_dest      = (w_op == c_OP_R) ? w_rd : w_rt;
  assign w_wb_data   = (w_op == c_OP_LW) ? r_mdr : r_aluout;

  assign w_funct_ok = (w_funct == c_FN_ADD) || (w_funct == c_FN_SUB) ||
                      (w_funct == c_FN_AND) || (w_funct == c_FN_OR)  ||
                      (w_funct == c_FN_SLT);
  assign w_op_ok    = ((w_op == c_OP_R) && w_funct_ok) || (w_op == c_OP_J) ||
                      (w_op == c_OP_BEQ) || (w_op == c_OP_BNE) ||
                      (w_op == c_OP_ADDI) || (w_op == c_OP_LW) || (w_op == c_OP_SW);

  // Immediate forms (addi/lw/sw) all use A + sext(imm); R-type selects by funct.
  always_comb begin
    w_alu = r_a + w_sext;
    if (w_op == c_OP_R) begin
      case (w_funct)
        c_FN_ADD: w_alu = r_a + r_b;
        c_FN_SUB: w_alu = r_a - r_b;
        c_FN_AND: w_alu = r_a & r_b;
        c_FN_OR:  w_alu = r_a | r_b;
        c_FN_SLT: w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
        default:  w_alu = r_a + r_b;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_npc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir    <= mem_rdata;
            r_npc   <= r_pc + 32'd4;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= r_regs[w_rs];
          r_b     <= r_regs[w_rt];
          r_state <= w_op_ok ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          r_aluout <= w_alu;
          case (w_op)
            c_OP_R, c_OP_ADDI: r_state <= S_WB;
            c_OP_LW, c_OP_SW:  r_state <= (w_alu[1:0] != 2'b00) ? S_HALT : S_MEM;
            c_OP_BEQ: begin
              r_pc    <= (r_a == r_b) ? w_br_target : r_npc;
              r_state <= S_FETCH;
            end
            c_OP_BNE: begin
              r_pc    <= (r_a != r_b) ? w_br_target : r_npc;
              r_state <= S_FETCH;
            end
            c_OP_J: begin
              r_pc    <= w_j_target;
              r_state <= S_FETCH;
            end
            default: r_state <= S_HALT;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (w_op == c_OP_SW) begin
              r_pc    <= r_npc;
              r_state <= S_FETCH;
            end else begin
              r_mdr   <= mem_rdata;
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          r_pc    <= r_npc;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Entry 0 is cleared and never written, so it always reads as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if ((r_state == S_WB) && (w_dest != 5'd0)) begin
      r_regs[w_dest] <= w_wb_data;
    end
  end

  assign mem_req   = reset && ((r_state == S_FETCH) || (r_state == S_MEM));
  assign mem_we    = (r_state == S_MEM) && (w_op == c_OP_SW);
  assign mem_addr  = (r_state == S_MEM) ? r_aluout[ADDR_W-1:0] : r_pc[ADDR_W-1:0];
  assign mem_wdata = r_b;
  assign pc        = r_pc;
  assign state     = r_state;
  assign halted    = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
// ============================================================================
// Module   : tb_multicycle_cpu
// Brief    : Self-checking bench for multicycle_cpu with a wait-state memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_cpu #(.RESET_PC(32'h0000_0100), .ADDR_W(32)) dut (
    .clock(clk), .reset(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .state(state), .halted(halted)
  );

  logic [31:0] mem [1024];
  logic [31:0] prog [$];
  int   total = 0, bad = 0;
  int   wait_cfg = 0, wait_cnt = 0, cur_wait = 0, stab_err = 0;
  bit   rnd_wait = 0, in_txn = 0;
  logic [31:0] l_addr, l_wdata;
  logic        l_we;

  // Memory responder: decides ready for the next edge, checks request stability.
  always @(negedge clk) begin
    if (rst_n && mem_req) begin
      if (!in_txn) begin
        in_txn   = 1;
        wait_cnt = 0;
        cur_wait = rnd_wait ? int'($urandom_range(0, 3)) : wait_cfg;
      end else if (l_addr !== mem_addr || l_we !== mem_we || (mem_we && l_wdata !== mem_wdata)) begin
        stab_err++;
      end
      l_addr = mem_addr; l_we = mem_we; l_wdata = mem_wdata;
      mem_rdata = mem[mem_addr[11:2]];
      if (wait_cnt >= cur_wait) begin
        mem_ready = 1'b1;
        in_txn    = 0;
      end else begin
        mem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      in_txn    = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  always @(posedge clk)
    if (rst_n && mem_req && mem_ready && mem_we) mem[mem_addr[11:2]] = mem_wdata;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) mem[64 + i] = prog[i];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Runs one instruction: leave FETCH, then return to FETCH or reach HALT.
  task automatic step(input int budget, output int cyc);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (state == 3'd0 && cyc < budget);
    while (state != 3'd0 && state != 3'd5 && cyc < budget) begin @(posedge clk); #1; cyc++; end
    total++;
    if (cyc >= budget) begin bad++; $display("FAIL step_timeout: cycles=%0d budget=%0d", cyc, budget); end
  endtask

  task automatic run_until(input logic [31:0] target, input int budget);
    int cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!(state == 3'd0 && pc == target) && cyc < budget);
    total++;
    if (!(state == 3'd0 && pc == target)) begin
      bad++; $display("FAIL run_until: pc=%h state=%0d want pc=%h", pc, state, target);
    end
  endtask

  task automatic test_reset();
    prog = '{enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF)};
    load_prog();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || halted !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: req=%b we=%b halted=%b want 0 0 0", mem_req, mem_we, halted); end
    total++; if (mem_addr !== 32'h100 || pc !== 32'h100) begin
      bad++; $display("FAIL reset_pc: addr=%h pc=%h want 00000100", mem_addr, pc); end
    total++; if (mem_wdata !== 32'h0 || state !== 3'd0) begin
      bad++; $display("FAIL reset_misc: wdata=%h state=%0d want 0 0", mem_wdata, state); end
    for (int i = 0; i < 32; i++) begin
      total++; if (dut.r_regs[i] !== 32'h0) begin
        bad++; $display("FAIL reset_reg%0d: got %h want 0", i, dut.r_regs[i]); end
    end
    @(posedge clk); #1 rst_n = 1'b1; #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || state !== 3'd0) begin
      bad++; $display("FAIL first_fetch: req=%b addr=%h state=%0d want 1 00000100 0", mem_req, mem_addr, state); end
  endtask

  task automatic test_arith();
    int cyc;
    logic [31:0] exp [6] = '{0, 32'd5, 32'hFFFF_FFFD, 32'd2, 32'd1, 32'hFFFF_FFF8};
    prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD),
             enc_r(5'd1, 5'd2, 5'd3, 6'h20), enc_r(5'd2, 5'd1, 5'd4, 6'h2A),
             enc_r(5'd2, 5'd1, 5'd5, 6'h22), enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF)};
    load_prog(); wait_cfg = 0; rnd_wait = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(50, cyc);
      total++; if (cyc !== 4) begin bad++; $display("FAIL arith_cycles%0d: got %0d want 4", i, cyc); end
    end
    for (int r = 1; r < 6; r++) begin
      total++; if (dut.r_regs[r] !== exp[r]) begin
        bad++; $display("FAIL arith_reg%0d: got %h want %h", r, dut.r_regs[r], exp[r]); end
    end
  endtask

  task automatic test_ldst_wait();
    int cyc;
    prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h2B, 5'd0, 5'd1, 16'd8),
             enc_i(6'h23, 5'd0, 5'd6, 16'd8), enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF)};
    load_prog(); wait_cfg = 0; rnd_wait = 0; stab_err = 0;
    do_reset();
    step(50, cyc);
    wait_cfg = 2;
    step(50, cyc);
    total++; if (cyc !== 8) begin bad++; $display("FAIL sw_cycles: got %0d want 8", cyc); end
    total++; if (mem[2] !== 32'd5) begin bad++; $display("FAIL sw_data: got %h want 5", mem[2]); end
    step(50, cyc);
    total++; if (cyc !== 9) begin bad++; $display("FAIL lw_cycles: got %0d want 9", cyc); end
    total++; if (dut.r_regs[6] !== 32'd5) begin bad++; $display("FAIL lw_data: got %h want 5", dut.r_regs[6]); end
    total++; if (stab_err !== 0) begin bad++; $display("FAIL req_stable: changes=%0d want 0", stab_err); end
    wait_cfg = 0;
  endtask

  task automatic test_branch();
    int cyc;
    logic [31:0] exp_pc [4] = '{32'h104, 32'h108, 32'h114, 32'h100};
    prog = '{enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF)};
    load_prog(); do_reset();
    for (int i = 0; i < 3; i++) begin
      step(50, cyc);
      total++; if (cyc !== 3 || pc !== 32'h100) begin
        bad++; $display("FAIL beq_loop%0d: cyc=%0d pc=%h want 3 00000100", i, cyc, pc); end
    end
    prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd7), enc_i(6'h05, 5'd1, 5'd1, 16'd4),
             enc_i(6'h05, 5'd1, 5'd0, 16'd2), 32'h0, 32'h0, {6'h02, 26'h40}};
    load_prog(); do_reset();
    for (int i = 0; i < 4; i++) begin
      step(50, cyc);
      total++; if (pc !== exp_pc[i] || cyc !== (i == 0 ? 4 : 3)) begin
        bad++; $display("FAIL branch%0d: pc=%h cyc=%0d want %h", i, pc, cyc, exp_pc[i]); end
    end
  endtask

  task automatic test_errors();
    int cyc, req_seen = 0;
    prog = '{32'hFC00_0000};
    load_prog(); do_reset();
    step(50, cyc);
    total++; if (halted !== 1'b1 || state !== 3'd5 || mem_req !== 1'b0) begin
      bad++; $display("FAIL illegal_op: halted=%b state=%0d req=%b want 1 5 0", halted, state, mem_req); end
    repeat (10) begin @(negedge clk); if (mem_req !== 1'b0 || pc !== 32'h100 || halted !== 1'b1) req_seen++; end
    total++; if (req_seen !== 0) begin bad++; $display("FAIL halt_sticky: bad_cycles=%0d want 0", req_seen); end
    prog = '{enc_i(6'h08, 5'd0, 5'd7, 16'd9), enc_i(6'h23, 5'd0, 5'd7, 16'd6)};
    load_prog(); do_reset();
    step(50, cyc);
    step(50, cyc);
    total++; if (halted !== 1'b1 || state !== 3'd5) begin
      bad++; $display("FAIL misaligned: halted=%b state=%0d want 1 5", halted, state); end
    repeat (3) @(posedge clk); #1;
    total++; if (dut.r_regs[7] !== 32'd9 || pc !== 32'h104) begin
      bad++; $display("FAIL misaligned_nowrite: r7=%h pc=%h want 9 00000104", dut.r_regs[7], pc); end
  endtask

  task automatic test_reset_mid_lw();
    int cyc, k = 0;
    prog = '{enc_i(6'h08, 5'd0, 5'd0, 16'd5), enc_i(6'h23, 5'd0, 5'd8, 16'd8)};
    load_prog(); mem[2] = 32'h0000_1234; wait_cfg = 0; rnd_wait = 0;
    do_reset();
    step(50, cyc);
    total++; if (dut.r_regs[0] !== 32'h0) begin bad++; $display("FAIL r0_write: got %h want 0", dut.r_regs[0]); end
    @(posedge clk); #1;
    wait_cfg = 50;
    while (state !== 3'd3 && k < 10) begin @(posedge clk); #1; k++; end
    repeat (2) @(posedge clk); #1;
    total++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      bad++; $display("FAIL lw_waiting: state=%0d req=%b addr=%h want 3 1 00000008", state, mem_req, mem_addr); end
    rst_n = 1'b0; #1;
    total++; if (state !== 3'd0 || mem_req !== 1'b0 || pc !== 32'h100) begin
      bad++; $display("FAIL async_abort: state=%0d req=%b pc=%h want 0 0 00000100", state, mem_req, pc); end
    @(posedge clk); #1 rst_n = 1'b1; wait_cfg = 0; #1;
    total++; if (dut.r_regs[8] !== 32'h0 || dut.r_regs[0] !== 32'h0 || mem_addr !== 32'h100) begin
      bad++; $display("FAIL abort_noload: r8=%h r0=%h addr=%h want 0 0 00000100",
                      dut.r_regs[8], dut.r_regs[0], mem_addr); end
  endtask

  // Random ALU/load/store programs against an architectural model with random waits.
  task automatic test_random(input int n);
    logic [31:0] m [32];
    logic [31:0] dm [16];
    logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    prog = {};
    for (int i = 0; i < 32; i++) m[i] = 0;
    for (int i = 0; i < 16; i++) dm[i] = 0;
    for (int i = 0; i < n; i++) begin
      int kind = int'($urandom_range(0, 7));
      logic [4:0]  rs = 5'($urandom_range(0, 7)), rt = 5'($urandom_range(0, 7)), rd = 5'($urandom_range(0, 7));
      logic [15:0] imm = 16'($urandom);
      logic [31:0] v = 0;
      int off = int'($urandom_range(0, 15));
      if (kind == 0) begin
        prog.push_back(enc_i(6'h08, rs, rd, imm));
        v = m[rs] + 32'($signed(imm));
      end else if (kind <= 5) begin
        prog.push_back(enc_r(rs, rt, rd, fns[kind-1]));
        case (kind)
          1: v = m[rs] + m[rt];
          2: v = m[rs] - m[rt];
          3: v = m[rs] & m[rt];
          4: v = m[rs] | m[rt];
          default: v = ($signed(m[rs]) < $signed(m[rt])) ? 32'd1 : 32'd0;
        endcase
      end else if (kind == 6) begin
        prog.push_back(enc_i(6'h2B, 5'd0, rt, 16'(off * 4)));
        dm[off] = m[rt];
      end else begin
        prog.push_back(enc_i(6'h23, 5'd0, rd, 16'(off * 4)));
        v = dm[off];
      end
      if (kind != 6 && rd != 0) m[rd] = v;
    end
    prog.push_back(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    load_prog(); rnd_wait = 1; stab_err = 0;
    do_reset();
    run_until(32'h100 + 32'(4 * n), n * 20 + 50);
    for (int r = 0; r < 8; r++) begin
      total++; if (dut.r_regs[r] !== m[r]) begin
        bad++; $display("FAIL rand_reg%0d: got %h want %h", r, dut.r_regs[r], m[r]); end
    end
    for (int a = 0; a < 16; a++) begin
      total++; if (mem[a] !== dm[a]) begin
        bad++; $display("FAIL rand_mem%0d: got %h want %h", a, mem[a], dm[a]); end
    end
    total++; if (halted !== 1'b0 || stab_err !== 0) begin
      bad++; $display("FAIL rand_status: halted=%b unstable=%0d want 0 0", halted, stab_err); end
    rnd_wait = 0;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_arith();
    test_ldst_wait();
    test_branch();
    test_errors();
    test_reset_mid_lw();
    test_random(24);
    test_random(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
